irq_controller: RTL and testbench

External interrupt controller sitting directly upstream of the privilege block: it collects up to NUM_SRC peripheral interrupt lines, synchronises and edge-detects them, latches pending bits, and drives the single I_extinterrupt input of the privilege block. Software reaches it through a word-addressed register port on the data bus and uses a claim/complete handshake to identify and retire sources. Lowest source index wins when several are pending.

---
 rtl/irq_controller.sv | 113 +++++++++++
 tb/tb_irq_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// External interrupt controller: synchronises and edge-detects peripheral lines,
// latches pending bits and arbitrates them (lowest index first) through a claim/complete port.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_SRC-1:0] I_irq,
  input  logic               I_wen,
  input  logic               I_ren,
  input  logic [3:0]         I_addr,
  input  logic [31:0]        I_wdata,
  output logic [31:0]        O_rdata,
  output logic               O_extinterrupt
);

  typedef enum logic [1:0] {
    REG_PENDING   = 2'd0,
    REG_ENABLE    = 2'd1,
    REG_CLAIM     = 2'd2,
    REG_INSERVICE = 2'd3
  } reg_e;

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] ins_q, ins_d;
  logic [NUM_SRC-1:0] edge_w, elig, first_mask, take_mask, done_mask;
  logic [4:0]         claim_id;
  logic [31:0]        rdata_q, rdata_d;
  logic               ext_q;
  logic               claim_rd;
  reg_e               sel;

  // Address LSBs and write-data bits beyond the register width are don't-care.
  logic unused_bits;
  assign unused_bits = ^{I_addr, I_wdata};

  assign sel      = reg_e'(I_addr[3:2]);
  assign edge_w   = s2_q & ~s3_q;
  assign elig     = pend_q & en_q & ~ins_q;
  assign claim_rd = I_ren && !I_wen && (sel == REG_CLAIM);

  always_comb begin
    logic found;
    found      = 1'b0;
    claim_id   = '0;
    first_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !found) begin
        found         = 1'b1;
        claim_id      = 5'(i + 1);
        first_mask[i] = 1'b1;
      end
    end
  end

  // Complete only matches IDs 1..NUM_SRC, so bad IDs and idle sources drop out naturally.
  always_comb begin
    done_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (I_wen && (sel == REG_CLAIM) && (I_wdata[4:0] == 5'(i + 1))) begin
        done_mask[i] = 1'b1;
      end
    end
  end

  assign take_mask = claim_rd ? first_mask : '0;
  assign pend_d    = (pend_q & ~take_mask) | edge_w;
  assign ins_d     = (ins_q | take_mask) & ~done_mask;
  assign en_d      = (I_wen && (sel == REG_ENABLE)) ? I_wdata[NUM_SRC-1:0] : en_q;

  always_comb begin
    rdata_d = rdata_q;
    if (I_wen && I_ren) begin
      rdata_d = '0;
    end else if (I_ren) begin
      unique case (sel)
        REG_PENDING:   rdata_d = 32'(pend_q);
        REG_ENABLE:    rdata_d = 32'(en_q);
        REG_CLAIM:     rdata_d = 32'(claim_id);
        REG_INSERVICE: rdata_d = 32'(ins_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      ins_q   <= '0;
      rdata_q <= '0;
      ext_q   <= 1'b0;
    end else begin
      s1_q    <= I_irq;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      en_q    <= en_d;
      ins_q   <= ins_d;
      rdata_q <= rdata_d;
      ext_q   <= |elig;
    end
  end

  assign O_rdata        = rdata_q;
  assign O_extinterrupt = ext_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed checks of irq_controller against a history-based reference model.
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        wen, ren;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ext;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(.NUM_SRC(8)) dut (
    .I_clk          (clk),
    .I_rst          (rst),
    .I_irq          (irq),
    .I_wen          (wen),
    .I_ren          (ren),
    .I_addr         (addr),
    .I_wdata        (wdata),
    .O_rdata        (rdata),
    .O_extinterrupt (ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: line samples seen at each clock edge, plus architectural registers.
  logic [7:0]  hist[$];
  logic [7:0]  m_pend, m_en, m_ins;
  logic        m_ext;
  logic [31:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // A source pends at edge E when its line was sampled high at E-2 and low at E-3.
  task automatic model_edge();
    logic [7:0] rose, elig, pend_n, ins_n;
    logic [4:0] id;
    if (rst) begin
      m_pend = '0; m_en = '0; m_ins = '0; m_ext = 1'b0; m_rd = '0;
      hist.push_back(8'h00);
    end else begin
      rose   = hist[hist.size()-2] & ~hist[hist.size()-3];
      elig   = m_pend & m_en & ~m_ins;
      pend_n = m_pend;
      ins_n  = m_ins;
      if (wen) begin
        if (addr[3:2] == 2'd1) m_en = wdata[7:0];
        if (addr[3:2] == 2'd2) begin
          id = wdata[4:0];
          if (id >= 5'd1 && id <= 5'd8) ins_n[id-1] = 1'b0;
        end
        if (ren) m_rd = '0;
      end else if (ren) begin
        case (addr[3:2])
          2'd0: m_rd = {24'h0, m_pend};
          2'd1: m_rd = {24'h0, m_en};
          2'd3: m_rd = {24'h0, m_ins};
          default: begin
            id = 5'd0;
            for (int i = 7; i >= 0; i--) if (elig[i]) id = 5'(i + 1);
            m_rd = {27'h0, id};
            if (id != 5'd0) begin
              pend_n[id-1] = 1'b0;
              ins_n[id-1]  = 1'b1;
            end
          end
        endcase
      end
      m_pend = pend_n | rose;
      m_ins  = ins_n;
      m_ext  = |elig;
      hist.push_back(irq);
    end
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("ext", {31'h0, ext}, {31'h0, m_ext});
    check("rdata", rdata, m_rd);
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; wdata = d;
    tick();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    ren = 1'b1; addr = a;
    tick();
    v = rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq = irq | m;
    tick();
    irq = irq & ~m;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; irq = '0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
    repeat (3) hist.push_back(8'h00);
    m_pend = '0; m_en = '0; m_ins = '0; m_ext = 1'b0; m_rd = '0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_ext", {31'h0, ext}, 32'h0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // Reset values and ENABLE read-back
    rd(4'h0, v); check("rst_pending", v, 32'h0);
    rd(4'h4, v); check("rst_enable", v, 32'h0);
    rd(4'hC, v); check("rst_inservice", v, 32'h0);
    wr(4'h4, 32'hFFFF_FFFF);
    rd(4'h4, v); check("enable_ff", v, 32'h0000_00FF);

    // Single source through claim and complete
    wr(4'h4, 32'h04);
    pulse(8'h04);
    idle(2);
    check("ext_n2", {31'h0, ext}, 32'h0);
    idle(1);
    check("ext_n3", {31'h0, ext}, 32'h1);
    rd(4'h0, v); check("pend_src2", v, 32'h04);
    rd(4'h8, v); check("claim_src2", v, 32'h3);
    rd(4'h0, v); check("pend_cleared", v, 32'h0);
    check("ext_after_claim", {31'h0, ext}, 32'h0);
    rd(4'hC, v); check("ins_src2", v, 32'h04);
    wr(4'h8, 32'h3);
    rd(4'hC, v); check("ins_done", v, 32'h0);

    // Pending without enable
    wr(4'h4, 32'h00);
    pulse(8'h02);
    idle(3);
    rd(4'h0, v); check("pend_disabled", v, 32'h02);
    rd(4'h8, v); check("claim_none", v, 32'h0);
    rd(4'hC, v); check("ins_unchanged", v, 32'h0);
    wr(4'h4, 32'h02);
    idle(1);
    check("ext_on_enable", {31'h0, ext}, 32'h1);
    rd(4'h8, v); check("claim_src1", v, 32'h2);
    wr(4'h8, 32'h2);

    // Two sources, lowest index first
    wr(4'h4, 32'hFF);
    pulse(8'h22);
    idle(3);
    rd(4'h8, v); check("claim_first", v, 32'h2);
    check("ext_still_high", {31'h0, ext}, 32'h1);
    rd(4'h8, v); check("claim_second", v, 32'h6);
    rd(4'h8, v); check("claim_empty", v, 32'h0);
    check("ext_dropped", {31'h0, ext}, 32'h0);
    wr(4'h8, 32'h6);
    wr(4'h8, 32'h2);

    // In-service source masks its own re-pend until completed; bad IDs are ignored
    pulse(8'h01);
    idle(3);
    rd(4'h8, v); check("claim_src0", v, 32'h1);
    pulse(8'h01);
    idle(3);
    rd(4'h0, v); check("repend_src0", v, 32'h01);
    check("ext_masked", {31'h0, ext}, 32'h0);
    wr(4'h8, 32'h0);
    wr(4'h8, 32'h9);
    rd(4'hC, v); check("ins_after_bad", v, 32'h01);
    wr(4'h8, 32'h1);
    idle(1);
    check("ext_after_done", {31'h0, ext}, 32'h1);
    rd(4'h8, v); check("claim_src0_again", v, 32'h1);
    wr(4'h8, 32'h1);

    // Simultaneous read and write: write happens, read data zero, no claim
    pulse(8'h10);
    idle(3);
    wen = 1'b1; ren = 1'b1; addr = 4'h8; wdata = 32'h0;
    tick();
    check("rw_zero", rdata, 32'h0);
    rd(4'h0, v); check("rw_no_claim", v, 32'h10);
    rd(4'h8, v); check("claim_src4", v, 32'h5);
    wr(4'h8, 32'h5);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin wen = 1'b1; addr = 4'h4; wdata = $urandom; end
        1: begin wen = 1'b1; addr = 4'h8; wdata = {$urandom_range(0, 7) == 0 ? 27'($urandom) : 27'h0, 5'($urandom_range(0, 10))}; end
        2, 3: begin ren = 1'b1; addr = 4'h8; end
        4: begin ren = 1'b1; addr = 4'($urandom); wen = ($urandom_range(0, 7) == 0); wdata = $urandom; end
        default: ;
      endcase
      tick();
    end

    // Asynchronous reset mid-cycle with a level held high
    irq = 8'h08;
    wr(4'h4, 32'hFF);
    wr(4'h8, 32'h4);
    idle(4);
    rd(4'h8, v);
    #2;
    rst = 1'b1;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_ext", {31'h0, ext}, 32'h0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    rd(4'h0, v); check("post_rst_n", v, 32'h0);
    rd(4'h0, v); check("post_rst_n1", v, 32'h0);
    rd(4'h0, v); check("post_rst_n2", v, 32'h0);
    rd(4'h0, v); check("post_rst_n3", v, 32'h08);
    idle(3);
    rd(4'h0, v); check("level_single_pend", v, 32'h08);
    irq = '0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
